// File: rtl/spi_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_ram                                                         |
// | Purpose  : Single-port command-decoded RAM behind an SPI slave; din[9:8]   |
// |            selects set-write-addr / write / set-read-addr / read.          |
// | Option   : SPI_RAM_SEQ_CHK_EN enables address-before-access sequence FSMs. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int MEM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MEM_WIDTH+1:0] din,
  input  logic                 rx_valid,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 tx_valid,
  output logic                 cmd_err
);

  localparam logic [1:0] c_cmd_wr_addr = 2'b00;
  localparam logic [1:0] c_cmd_wr_data = 2'b01;
  localparam logic [1:0] c_cmd_rd_addr = 2'b10;
  localparam int         c_idx_w       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0] c_depth = (ADDR_SIZE + 1)'(MEM_DEPTH);

  logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic [MEM_WIDTH-1:0] r_dout;
  logic                 r_tx_valid;
  logic                 r_cmd_err;

  logic [1:0]           w_cmd;
  logic [MEM_WIDTH-1:0] w_payload;
  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic                 w_wr_seq_ok;
  logic                 w_rd_seq_ok;
  logic                 w_wr_cmd;
  logic                 w_rd_cmd;
  logic                 w_do_write;
  logic                 w_err;
  logic [MEM_WIDTH-1:0] w_rd_data;

  assign w_cmd         = din[MEM_WIDTH+1:MEM_WIDTH];
  assign w_payload     = din[MEM_WIDTH-1:0];
  assign w_wr_in_range = ({1'b0, r_wr_addr} < c_depth);
  assign w_rd_in_range = ({1'b0, r_rd_addr} < c_depth);
  assign w_wr_cmd      = rx_valid && (w_cmd == c_cmd_wr_data);
  assign w_rd_cmd      = rx_valid && (w_cmd == 2'b11);

`ifdef SPI_RAM_SEQ_CHK_EN
  typedef enum logic [0:0] {W_ADDR = 1'b0, W_DATA = 1'b1} wr_state_t;
  typedef enum logic [0:0] {R_ADDR = 1'b0, R_DATA = 1'b1} rd_state_t;

  wr_state_t r_wr_state;
  wr_state_t w_wr_state_nxt;
  rd_state_t r_rd_state;
  rd_state_t w_rd_state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= W_ADDR;
      r_rd_state <= R_ADDR;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
    end
  end

  // Write and read sequences advance independently of each other.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_rd_state_nxt = r_rd_state;
    if (rx_valid) begin
      case (w_cmd)
        c_cmd_wr_addr: w_wr_state_nxt = W_DATA;
        c_cmd_wr_data: w_wr_state_nxt = W_ADDR;
        c_cmd_rd_addr: w_rd_state_nxt = R_DATA;
        default:       w_rd_state_nxt = R_ADDR;
      endcase
    end
  end

  assign w_wr_seq_ok = (r_wr_state == W_DATA);
  assign w_rd_seq_ok = (r_rd_state == R_DATA);
`else
  assign w_wr_seq_ok = 1'b1;
  assign w_rd_seq_ok = 1'b1;
`endif

  assign w_do_write = w_wr_cmd && w_wr_seq_ok && w_wr_in_range;
  assign w_err      = (w_wr_cmd && !(w_wr_seq_ok && w_wr_in_range)) ||
                      (w_rd_cmd && !(w_rd_seq_ok && w_rd_in_range));
  // Out-of-range reads return zero rather than touching the array.
  assign w_rd_data  = w_rd_in_range ? r_mem[r_rd_addr[c_idx_w-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[r_wr_addr[c_idx_w-1:0]] <= w_payload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_cmd_err <= w_err;
      if (rx_valid) begin
        case (w_cmd)
          c_cmd_wr_addr: begin
            r_wr_addr  <= w_payload[ADDR_SIZE-1:0];
            r_tx_valid <= 1'b0;
          end
          c_cmd_wr_data: r_tx_valid <= 1'b0;
          c_cmd_rd_addr: begin
            r_rd_addr  <= w_payload[ADDR_SIZE-1:0];
            r_tx_valid <= 1'b0;
          end
          default: begin
            if (w_rd_seq_ok) begin
              r_dout     <= w_rd_data;
              r_tx_valid <= 1'b1;
            end else begin
              r_tx_valid <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;
  assign cmd_err  = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram.sv
`default_nettype none
// Bench for spi_ram: a full-size and a 128-deep instance share one command
// stream and are compared each cycle against a command-level model.
module tb_spi_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;

  logic [7:0] dout_a, dout_b;
  logic       tx_a, tx_b, err_a, err_b;

  int errors = 0;
  int checks = 0;

`ifdef SPI_RAM_SEQ_CHK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .MEM_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout_a), .tx_valid(tx_a), .cmd_err(err_a)
  );

  spi_ram #(.MEM_DEPTH(128), .ADDR_SIZE(8), .MEM_WIDTH(8)) dut_small (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout_b), .tx_valid(tx_b), .cmd_err(err_b)
  );

  always #5 clk = ~clk;

  // Command-level reference model, one slot per instance.
  int         depth [2] = '{256, 128};
  logic [7:0] m_mem [2][256];
  bit         m_known [2][256];
  logic [7:0] m_dout [2];
  bit         m_dk [2];
  bit         m_tx [2], m_err [2], m_wv [2], m_rv [2];
  int         m_wr [2], m_rd [2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_dout[k] = 8'h00; m_dk[k] = 1'b1; m_tx[k] = 1'b0; m_err[k] = 1'b0;
        m_wr[k] = 0; m_rd[k] = 0; m_wv[k] = 1'b0; m_rv[k] = 1'b0;
      end else begin
        m_err[k] = 1'b0;
        if (rx_valid) begin
          case (din[9:8])
            2'b00: begin m_wr[k] = int'(din[7:0]); m_wv[k] = 1'b1; m_tx[k] = 1'b0; end
            2'b01: begin
              if (SEQ && !m_wv[k]) m_err[k] = 1'b1;
              else if (m_wr[k] < depth[k]) begin
                m_mem[k][m_wr[k]] = din[7:0]; m_known[k][m_wr[k]] = 1'b1;
              end else m_err[k] = 1'b1;
              m_wv[k] = 1'b0; m_tx[k] = 1'b0;
            end
            2'b10: begin m_rd[k] = int'(din[7:0]); m_rv[k] = 1'b1; m_tx[k] = 1'b0; end
            default: begin
              if (SEQ && !m_rv[k]) begin
                m_err[k] = 1'b1; m_tx[k] = 1'b0;
              end else begin
                m_tx[k] = 1'b1;
                if (m_rd[k] < depth[k]) begin
                  m_dout[k] = m_mem[k][m_rd[k]]; m_dk[k] = m_known[k][m_rd[k]];
                end else begin
                  m_dout[k] = 8'h00; m_dk[k] = 1'b1; m_err[k] = 1'b1;
                end
              end
              m_rv[k] = 1'b0;
            end
          endcase
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model tx_valid a", {7'b0, tx_a}, {7'b0, m_tx[0]});
    check("model tx_valid b", {7'b0, tx_b}, {7'b0, m_tx[1]});
    check("model cmd_err a", {7'b0, err_a}, {7'b0, m_err[0]});
    check("model cmd_err b", {7'b0, err_b}, {7'b0, m_err[1]});
    if (m_dk[0]) check("model dout a", dout_a, m_dout[0]);
    if (m_dk[1]) check("model dout b", dout_b, m_dout[1]);
  end

  // Present one command for exactly one sampling edge; returns 1 time unit after it.
  task automatic send(input logic [9:0] w);
    din = w; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; din = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset dout", dout_a, 8'h00);
    check("reset tx_valid", {7'b0, tx_a}, 8'h00);
    check("reset cmd_err", {7'b0, err_a}, 8'h00);
    rst = 1'b0;

    // Preload known contents, then reset (memory survives reset).
    send(10'h006); send(10'h13C);
    send(10'h000); send(10'h111);
    send(10'h07F); send(10'h177);
    idle(2);
    do_reset();

    send(10'h005); send(10'h1A5); send(10'h205); send(10'h300);
    check("rd A5 dout", dout_a, 8'hA5);
    check("rd A5 tx_valid", {7'b0, tx_a}, 8'h01);
    check("rd A5 small dout", dout_b, 8'hA5);

    send(10'h005);
    check("clr tx_valid", {7'b0, tx_a}, 8'h00);
    check("clr dout hold", dout_a, 8'hA5);

    idle(1);
    send(10'h205); send(10'h300);
    check("b2b rd1 dout", dout_a, 8'hA5);
    send(10'h206); send(10'h300);
    check("b2b rd2 dout", dout_a, 8'h3C);
    check("b2b rd2 tx_valid", {7'b0, tx_a}, 8'h01);

    // Data write with no preceding address command.
    do_reset();
    send(10'h1FF);
    check("orphan wr cmd_err", {7'b0, err_a}, SEQ ? 8'h01 : 8'h00);
    idle(1);
    check("orphan wr err pulse end", {7'b0, err_a}, 8'h00);
    send(10'h300);
    check("orphan rd tx_valid", {7'b0, tx_a}, SEQ ? 8'h00 : 8'h01);
    send(10'h200); send(10'h300);
    check("addr0 after orphan wr", dout_a, SEQ ? 8'h11 : 8'hFF);

    // Address 0x80 is out of range only for the 128-deep instance.
    send(10'h080); send(10'h1AB);
    check("oor wr err small", {7'b0, err_b}, 8'h01);
    check("in-range wr err big", {7'b0, err_a}, 8'h00);
    send(10'h280); send(10'h300);
    check("oor rd dout small", dout_b, 8'h00);
    check("oor rd tx_valid small", {7'b0, tx_b}, 8'h01);
    check("oor rd err small", {7'b0, err_b}, 8'h01);
    check("rd 0x80 big", dout_a, 8'hAB);

    // Asynchronous reset while tx_valid is high.
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async rst tx_valid", {7'b0, tx_a}, 8'h00);
    check("async rst dout", dout_a, 8'h00);
    check("async rst small tx_valid", {7'b0, tx_b}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
